// File: rtl/mem_access_stage.sv
// Memory-access stage: ALU ops retire 1 cycle after accept, loads/stores 1 cycle after gnt/rvalid.
// Execute is held off (in_ready=0) while a memory transaction is outstanding; write-back never stalls.
module mem_access_stage #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int REG_AW  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic              in_reg_write,
   input  logic [REG_AW-1:0] in_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_result,
   output logic              out_wen,
   output logic [REG_AW-1:0] out_rd,
   output logic              mem_err
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // Instruction fields captured on accept; execute may change its outputs afterwards.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              is_load;
      logic              reg_write;
      logic [REG_AW-1:0] rd;
   } txn_t;

   state_t            state_q, state_d;
   txn_t              txn_q, txn_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_valid_d;
   logic              out_wen_d;
   logic [DATA_W-1:0] out_result_d;
   logic [REG_AW-1:0] out_rd_d;
   logic              mem_err_d;
   logic              busy;
   logic              done;

   always_comb begin
      state_d      = state_q;
      txn_d        = txn_q;
      cnt_d        = cnt_q;
      out_valid_d  = 1'b0;
      out_wen_d    = 1'b0;
      out_result_d = out_result;
      out_rd_d     = out_rd;
      mem_err_d    = mem_err;
      busy         = (state_q != S_IDLE);
      done         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_mem_read || in_mem_write) begin
                  state_d         = S_REQ;
                  txn_d.addr      = in_alu_result[ADDR_W-1:0];
                  txn_d.wdata     = in_store_data;
                  txn_d.is_load   = in_mem_read;
                  txn_d.reg_write = in_reg_write;
                  txn_d.rd        = in_rd;
                  cnt_d           = '0;
               end else begin
                  out_valid_d  = 1'b1;
                  out_result_d = in_alu_result;
                  out_wen_d    = in_reg_write;
                  out_rd_d     = in_rd;
               end
            end
         end
         S_REQ: begin
            // A load whose data returns with the grant skips WAIT entirely.
            if (mem_gnt && (!txn_q.is_load || mem_rvalid)) begin
               done = 1'b1;
            end else if (mem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               done = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A response arriving on the last allowed cycle still completes normally.
      if (done) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b1;
         out_rd_d    = txn_q.rd;
         out_wen_d   = txn_q.is_load && txn_q.reg_write;
         if (txn_q.is_load) begin
            out_result_d = mem_rdata;
         end
      end else if (busy && (TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
         state_d      = S_IDLE;
         out_valid_d  = 1'b1;
         out_result_d = '0;
         out_rd_d     = txn_q.rd;
         mem_err_d    = 1'b1;
      end else if (busy && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         txn_q      <= '0;
         cnt_q      <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_wen    <= 1'b0;
         out_rd     <= '0;
         mem_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         txn_q      <= txn_d;
         cnt_q      <= cnt_d;
         out_valid  <= out_valid_d;
         out_result <= out_result_d;
         out_wen    <= out_wen_d;
         out_rd     <= out_rd_d;
         mem_err    <= mem_err_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign mem_req   = (state_q == S_REQ);
   assign mem_we    = mem_req && !txn_q.is_load;
   assign mem_addr  = mem_req ? txn_q.addr : '0;
   assign mem_wdata = mem_we ? txn_q.wdata : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: two instances (default timeout and TIMEOUT=4) share stimulus;
// sel4 selects which one is observed.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_alu_result = '0;
   logic [15:0] in_store_data = '0;
   logic        in_mem_read = 1'b0;
   logic        in_mem_write = 1'b0;
   logic        in_reg_write = 1'b0;
   logic [3:0]  in_rd = '0;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [15:0] mem_rdata = '0;

   logic        a_in_ready, a_mem_req, a_mem_we, a_out_valid, a_out_wen, a_mem_err;
   logic [15:0] a_mem_addr, a_mem_wdata, a_out_result;
   logic [3:0]  a_out_rd;
   logic        b_in_ready, b_mem_req, b_mem_we, b_out_valid, b_out_wen, b_mem_err;
   logic [15:0] b_mem_addr, b_mem_wdata, b_out_result;
   logic [3:0]  b_out_rd;

   logic        sel4 = 1'b0;
   logic        in_ready, mem_req, mem_we, out_valid, out_wen, mem_err;
   logic [15:0] mem_addr, mem_wdata, out_result;
   logic [3:0]  out_rd;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_alu_result(in_alu_result), .in_store_data(in_store_data),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
      .in_rd(in_rd), .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .out_valid(a_out_valid), .out_result(a_out_result), .out_wen(a_out_wen),
      .out_rd(a_out_rd), .mem_err(a_mem_err)
   );

   mem_access_stage #(.TIMEOUT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_alu_result(in_alu_result), .in_store_data(in_store_data),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
      .in_rd(in_rd), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .out_valid(b_out_valid), .out_result(b_out_result), .out_wen(b_out_wen),
      .out_rd(b_out_rd), .mem_err(b_mem_err)
   );

   assign in_ready   = sel4 ? b_in_ready   : a_in_ready;
   assign mem_req    = sel4 ? b_mem_req    : a_mem_req;
   assign mem_we     = sel4 ? b_mem_we     : a_mem_we;
   assign mem_addr   = sel4 ? b_mem_addr   : a_mem_addr;
   assign mem_wdata  = sel4 ? b_mem_wdata  : a_mem_wdata;
   assign out_valid  = sel4 ? b_out_valid  : a_out_valid;
   assign out_result = sel4 ? b_out_result : a_out_result;
   assign out_wen    = sel4 ? b_out_wen    : a_out_wen;
   assign out_rd     = sel4 ? b_out_rd     : a_out_rd;
   assign mem_err    = sel4 ? b_mem_err    : a_mem_err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit          err_model = 1'b0;
   bit          res_known = 1'b1;
   logic [15:0] last_res = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      err_model = 1'b0;
      res_known = 1'b1;
      last_res  = '0;
   endtask

   // One non-memory op, issued at a negedge; result expected at the following negedge.
   task automatic alu_op(input logic rw, input logic [3:0] rd, input logic [15:0] alu);
      chk("alu_pre_ready", in_ready, 1);
      in_valid = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b0;
      in_reg_write = rw; in_rd = rd; in_alu_result = alu;
      @(negedge clk);
      in_valid = 1'b0; in_alu_result = ~alu; in_rd = ~rd;
      chk("alu_ovld", out_valid, 1);
      chk("alu_res", out_result, alu);
      chk("alu_wen", out_wen, rw);
      chk("alu_rd", out_rd, rd);
      last_res = alu; res_known = 1'b1;
   endtask

   // Memory op. g: REQ cycle index carrying gnt; r: cycles from gnt to rvalid (loads).
   // The op completes on cycle index c; if c >= timeout limit it aborts on cycle limit-1.
   task automatic mem_txn(input bit ld, input bit st, input logic rw, input logic [3:0] rd,
                          input logic [15:0] alu, input logic [15:0] sdata,
                          input logic [15:0] rdata, input int g, input int r);
      int c, last, lim;
      bit tmo;
      lim = sel4 ? 4 : 255;
      c = ld ? g + r : g;
      tmo = (c >= lim);
      last = tmo ? lim - 1 : c;
      chk("mem_pre_ready", in_ready, 1);
      in_valid = 1'b1; in_mem_read = ld; in_mem_write = st; in_reg_write = rw;
      in_rd = rd; in_alu_result = alu; in_store_data = sdata;
      @(negedge clk);
      in_valid = 1'b0; in_alu_result = ~alu; in_store_data = ~sdata; in_rd = ~rd;
      for (int k = 0; k <= last; k++) begin
         chk("busy_ready", in_ready, 0);
         chk("busy_ovld", out_valid, 0);
         if (k <= g) begin
            chk("req_hold", mem_req, 1);
            chk("req_addr", mem_addr, alu);
            chk("req_we", mem_we, !ld);
            if (!ld) chk("req_wdata", mem_wdata, sdata);
         end else begin
            chk("wait_req", mem_req, 0);
         end
         mem_gnt = (k == g);
         mem_rvalid = ld && (k == g + r);
         mem_rdata = mem_rvalid ? rdata : 16'($urandom);
         @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      err_model = err_model | tmo;
      chk("done_ovld", out_valid, 1);
      chk("done_ready", in_ready, 1);
      chk("done_req", mem_req, 0);
      chk("done_err", mem_err, err_model);
      if (tmo) begin
         chk("tmo_res", out_result, 0);
         chk("tmo_wen", out_wen, 0);
         last_res = '0; res_known = 1'b1;
      end else if (ld) begin
         chk("ld_res", out_result, rdata);
         chk("ld_wen", out_wen, rw);
         chk("ld_rd", out_rd, rd);
         last_res = rdata; res_known = 1'b1;
      end else begin
         chk("st_wen", out_wen, 0);
         chk("st_rd", out_rd, rd);
         res_known = 1'b0;
      end
   endtask

   // Quiet cycle; optional stray gnt/rvalid must be ignored in IDLE.
   task automatic idle_cycle(input bit stray);
      mem_gnt = stray; mem_rvalid = stray; mem_rdata = 16'($urandom);
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("idle_ovld", out_valid, 0);
      chk("idle_wen", out_wen, 0);
      chk("idle_req", mem_req, 0);
      chk("idle_ready", in_ready, 1);
      chk("idle_err", mem_err, err_model);
      if (res_known) chk("idle_hold", out_result, last_res);
   endtask

   typedef struct {
      logic        rw;
      logic [3:0]  rd;
      logic [15:0] alu;
      logic        exp_wen;
      logic [3:0]  exp_rd;
      logic [15:0] exp_res;
   } vec_t;

   vec_t tbl[5];

   int          kind, g, r, n;
   logic [15:0] ra, rs, rdat;
   logic [3:0]  rrd;
   logic        rrw;

   initial begin
      tbl[0] = '{1'b1, 4'd3,  16'h1234, 1'b1, 4'd3,  16'h1234};
      tbl[1] = '{1'b0, 4'd7,  16'hA5A5, 1'b0, 4'd7,  16'hA5A5};
      tbl[2] = '{1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd15, 16'hFFFF};
      tbl[3] = '{1'b1, 4'd0,  16'h0000, 1'b1, 4'd0,  16'h0000};
      tbl[4] = '{1'b0, 4'd9,  16'h8001, 1'b0, 4'd9,  16'h8001};

      // Reset state
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_ovld", out_valid, 0);
      chk("rst_res", out_result, 0);
      chk("rst_wen", out_wen, 0);
      chk("rst_rd", out_rd, 0);
      chk("rst_err", mem_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      idle_cycle(1'b0);

      // Single ALU op, then back-to-back ALU ops giving continuous out_valid
      alu_op(1'b1, 4'd3, 16'h1234);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b0;
         in_reg_write = tbl[i].rw; in_rd = tbl[i].rd; in_alu_result = tbl[i].alu;
         @(negedge clk);
         chk("tbl_ovld", out_valid, 1);
         chk("tbl_res", out_result, tbl[i].exp_res);
         chk("tbl_wen", out_wen, tbl[i].exp_wen);
         chk("tbl_rd", out_rd, tbl[i].exp_rd);
      end
      in_valid = 1'b0;
      last_res = 16'h8001; res_known = 1'b1;
      idle_cycle(1'b0);

      // Load: gnt on third REQ cycle, rvalid three cycles later
      mem_txn(1'b1, 1'b0, 1'b1, 4'd5, 16'h00A4, 16'h0, 16'hBEEF, 2, 3);
      idle_cycle(1'b1);
      // Store granted on first REQ cycle, reg_write ignored
      mem_txn(1'b0, 1'b1, 1'b1, 4'd6, 16'h0100, 16'hCAFE, 16'h0, 0, 0);
      idle_cycle(1'b0);
      // Zero-wait load immediately followed by an ALU op
      mem_txn(1'b1, 1'b0, 1'b1, 4'd2, 16'h0200, 16'h0, 16'h7777, 0, 0);
      alu_op(1'b1, 4'd4, 16'h4242);
      idle_cycle(1'b0);

      // Timeout on the TIMEOUT=4 instance
      sel4 = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      mem_txn(1'b1, 1'b0, 1'b1, 4'd7, 16'h0040, 16'h0, 16'h5555, 100, 0);
      mem_gnt = 1'b1; mem_rvalid = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("late_req", mem_req, 0);
      chk("late_ovld", out_valid, 0);
      chk("late_ready", in_ready, 1);
      chk("late_err", mem_err, 1);
      idle_cycle(1'b0);

      // Asynchronous reset in the middle of a load
      in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_alu_result = 16'h0123;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_req", mem_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", mem_req, 0);
      chk("arst_ovld", out_valid, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_err", mem_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      idle_cycle(1'b1);

      // Randomised mix on the TIMEOUT=4 instance (includes timeouts)
      for (int it = 0; it < 120; it++) begin
         kind = $urandom_range(0, 3);
         ra = 16'($urandom); rs = 16'($urandom); rdat = 16'($urandom);
         rrd = 4'($urandom); rrw = 1'($urandom);
         g = $urandom_range(0, 5); r = $urandom_range(0, 3);
         case (kind)
            0: alu_op(rrw, rrd, ra);
            1: mem_txn(1'b1, 1'b0, rrw, rrd, ra, rs, rdat, g, r);
            2: mem_txn(1'b0, 1'b1, rrw, rrd, ra, rs, rdat, g, r);
            default: mem_txn(1'b1, 1'b1, rrw, rrd, ra, rs, rdat, g, r);
         endcase
         n = $urandom_range(0, 2);
         for (int j = 0; j < n; j++) idle_cycle(1'($urandom));
      end
      idle_cycle(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
